// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register indices,
// CAUSE/TYPE bit positions and the service-round state encoding.
package irq_ctrl_pkg;

  localparam logic [1:0] REG_PEND  = 2'd0;
  localparam logic [1:0] REG_EN    = 2'd1;
  localparam logic [1:0] REG_CAUSE = 2'd2;
  localparam logic [1:0] REG_TYPE  = 2'd3;

  localparam int CAUSE_VALID_BIT = 31;
  // On a TYPE/SET write this bit selects "load TYPE" over "software set".
  localparam int TYPE_WR_BIT     = 31;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_WAIT  = 2'd2,
    S_GAP   = 2'd3
  } irq_state_t;

endpackage

// File: rtl/irq_ctrl_if.sv
// IO-bus connection of the interrupt controller.
//   sel   : IO decoder select        rd/wr : CPU strobes
//   radr  : register index (adr[3:2]) wdata : CPU write data
//   rdata : read data, combinational from the slave
interface irq_ctrl_if;

  logic        sel;
  logic        rd;
  logic        wr;
  logic [1:0]  radr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, rd, wr, radr, wdata, input rdata);
  modport slave  (input sel, rd, wr, radr, wdata, output rdata);

endinterface

// File: rtl/irq_ctrl_src_cond.sv
// Per-source conditioner: two-flop synchroniser for an asynchronous source
// line plus an edge/level qualifier that yields a one-bit set strobe.
//   clk, rst  : clock, synchronous active-high reset
//   src       : raw source line (asynchronous)
//   edge_mode : 1 = set on rising edge, 0 = set while level is high
//   set       : strobe that sets the pending bit
module irq_ctrl_src_cond (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic edge_mode,
  output logic set
);

  logic s1, s2, s3;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= src;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign set = edge_mode ? (s2 & ~s3) : s2;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller. Merges NUM_IRQ sources into a single
// edge-detected irq line: one 1-cycle pulse per service round, then waits
// for software EOI (any write to CAUSE) before it may pulse again.
//   clk, rst : clock, synchronous active-high reset
//   src      : raw source lines (asynchronous)
//   bus      : IO-bus slave port (sel/rd/wr/radr/wdata in, rdata out)
//   irq      : registered interrupt request to the core
//
// state   | meaning
// --------+---------------------------------------------------------
// S_IDLE  | no round in progress; start one when pending & enable != 0
// S_PULSE | irq high for this single cycle
// S_WAIT  | round outstanding; new requests held until EOI
// S_GAP   | one low cycle after EOI so the core sees a fresh edge
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int                 NUM_IRQ  = 8,
  parameter logic [NUM_IRQ-1:0] EDGE_RST = {NUM_IRQ{1'b1}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] src,
  irq_ctrl_if.slave          bus,
  output logic               irq
);

  logic [NUM_IRQ-1:0] pending, enable, src_type, hw_set, active, wdata_n;
  logic [4:0]         cause_idx;
  logic [31:0]        cause_word;
  logic               req, wr_en, wr_clr, wr_enable, wr_type, wr_set, eoi;
  irq_state_t         state;
  logic               unused_wdata;

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_src
    irq_ctrl_src_cond u_cond (
      .clk       (clk),
      .rst       (rst),
      .src       (src[i]),
      .edge_mode (src_type[i]),
      .set       (hw_set[i])
    );
  end

  assign wdata_n      = bus.wdata[NUM_IRQ-1:0];
  assign unused_wdata = ^bus.wdata;

  assign wr_en     = bus.sel & bus.wr;
  assign wr_clr    = wr_en && (bus.radr == REG_PEND);
  assign wr_enable = wr_en && (bus.radr == REG_EN);
  assign eoi       = wr_en && (bus.radr == REG_CAUSE);
  assign wr_type   = wr_en && (bus.radr == REG_TYPE) &&  bus.wdata[TYPE_WR_BIT];
  assign wr_set    = wr_en && (bus.radr == REG_TYPE) && !bus.wdata[TYPE_WR_BIT];

  assign active = pending & enable;
  assign req    = |active;

  // Descending scan so the lowest-numbered active source is the last to win.
  always_comb begin
    cause_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (active[i]) cause_idx = 5'(i);
    end
  end

  always_comb begin
    cause_word                  = '0;
    cause_word[CAUSE_VALID_BIT] = req;
    cause_word[4:0]             = cause_idx;
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.sel && bus.rd) begin
      case (bus.radr)
        REG_PEND:  bus.rdata = 32'(pending);
        REG_EN:    bus.rdata = 32'(enable);
        REG_CAUSE: bus.rdata = cause_word;
        default:   bus.rdata = 32'(src_type);
      endcase
    end
  end

  // Hardware and software sets are OR-ed after the W1C mask, so a set
  // arriving in the same cycle as its clear keeps the bit at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      enable   <= '0;
      src_type <= EDGE_RST;
    end else begin
      pending <= (pending & ~(wr_clr ? wdata_n : '0))
               | hw_set
               | (wr_set ? wdata_n : '0);
      if (wr_enable) enable   <= wdata_n;
      if (wr_type)   src_type <= wdata_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      irq   <= 1'b0;
    end else begin
      irq <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            state <= S_PULSE;
            irq   <= 1'b1;
          end
        end
        S_PULSE: state <= S_WAIT;
        S_WAIT:  if (eoi) state <= S_GAP;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] src;
  logic         irq;

  irq_ctrl_if bus ();

  irq_ctrl #(.NUM_IRQ(N), .EDGE_RST(8'hFF)) dut (
    .clk (clk),
    .rst (rst),
    .src (src),
    .bus (bus.slave),
    .irq (irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus.sel = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.radr = 2'd0; bus.wdata = 32'd0;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.sel = 1'b1; bus.wr = 1'b1; bus.radr = a; bus.wdata = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic rd_chk(input string name, input logic [1:0] a, input logic [31:0] exp);
    @(negedge clk);
    bus.sel = 1'b1; bus.rd = 1'b1; bus.radr = a;
    #1 chk(name, bus.rdata, exp);
    bus_idle();
  endtask

  // Write, then read in the very next cycle (no idle cycle between).
  task automatic wr_then_rd(input logic [1:0] a, input logic [31:0] d,
                            input logic [1:0] ra, input logic [31:0] exp, input string name);
    @(negedge clk);
    bus.sel = 1'b1; bus.wr = 1'b1; bus.radr = a; bus.wdata = d;
    @(negedge clk);
    bus.wr = 1'b0; bus.rd = 1'b1; bus.radr = ra;
    #1 chk(name, bus.rdata, exp);
    bus_idle();
  endtask

  task automatic count_irq(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (irq) cnt++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; src = '0; bus_idle();
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        is_rd;
    logic        sel;
    logic [1:0]  radr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[19];

  // Reference model state
  logic [7:0] m_pend, m_en, m_type, h1, h2, h3;
  bit         m_irq, m_busy, m_cool;

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [7:0] act;
    logic [31:0] res;
    act = m_pend & m_en;
    res = 32'd0;
    case (a)
      2'd0: res = {24'd0, m_pend};
      2'd1: res = {24'd0, m_en};
      2'd2: begin
        if (act != 8'd0) begin
          res[31] = 1'b1;
          for (int i = 0; i < 8; i++) begin
            if (act[i]) begin
              res[4:0] = 5'(i);
              break;
            end
          end
        end
      end
      default: res = {24'd0, m_type};
    endcase
    return res;
  endfunction

  initial begin
    int c, c1, c2, r;
    logic [7:0] act, set, npend, w1c, sw;
    bit isw;

    rst = 1'b1; src = '0; bus_idle();
    repeat (2) @(negedge clk);

    // Reset values
    do_reset();
    chk("rst_irq", 32'(irq), 32'd0);
    rd_chk("rst_pend",  REG_PEND,  32'h0);
    rd_chk("rst_en",    REG_EN,    32'h0);
    rd_chk("rst_cause", REG_CAUSE, 32'h0);
    rd_chk("rst_type",  REG_TYPE,  32'hFF);

    // Register-access table
    tbl[0]  = '{1'b0, 1'b1, REG_EN,    32'h0000_00A5, 32'h0,          "wr_en_a5"};
    tbl[1]  = '{1'b1, 1'b1, REG_EN,    32'h0,          32'h0000_00A5, "rd_en_a5"};
    tbl[2]  = '{1'b0, 1'b1, REG_EN,    32'hFFFF_FFFF, 32'h0,          "wr_en_all"};
    tbl[3]  = '{1'b1, 1'b1, REG_EN,    32'h0,          32'h0000_00FF, "rd_en_trunc"};
    tbl[4]  = '{1'b1, 1'b1, REG_TYPE,  32'h0,          32'h0000_00FF, "rd_type_rst"};
    tbl[5]  = '{1'b0, 1'b1, REG_TYPE,  32'h8000_0012, 32'h0,          "wr_type"};
    tbl[6]  = '{1'b1, 1'b1, REG_TYPE,  32'h0,          32'h0000_0012, "rd_type"};
    tbl[7]  = '{1'b0, 1'b1, REG_TYPE,  32'h0000_0003, 32'h0,          "sw_set"};
    tbl[8]  = '{1'b1, 1'b1, REG_PEND,  32'h0,          32'h0000_0003, "rd_pend_sw"};
    tbl[9]  = '{1'b1, 1'b1, REG_CAUSE, 32'h0,          32'h8000_0000, "rd_cause_0"};
    tbl[10] = '{1'b0, 1'b1, REG_PEND,  32'h0000_0001, 32'h0,          "w1c_bit0"};
    tbl[11] = '{1'b1, 1'b1, REG_PEND,  32'h0,          32'h0000_0002, "rd_pend_w1c"};
    tbl[12] = '{1'b1, 1'b1, REG_CAUSE, 32'h0,          32'h8000_0001, "rd_cause_1"};
    tbl[13] = '{1'b0, 1'b1, REG_EN,    32'h0,          32'h0,          "wr_en_0"};
    tbl[14] = '{1'b1, 1'b1, REG_CAUSE, 32'h0,          32'h0,          "rd_cause_none"};
    tbl[15] = '{1'b0, 1'b0, REG_EN,    32'h0000_0055, 32'h0,          "wr_nosel"};
    tbl[16] = '{1'b1, 1'b1, REG_EN,    32'h0,          32'h0,          "rd_en_nosel"};
    tbl[17] = '{1'b0, 1'b1, REG_PEND,  32'hFFFF_FFFF, 32'h0,          "w1c_all"};
    tbl[18] = '{1'b1, 1'b1, REG_PEND,  32'h0,          32'h0,          "rd_pend_clr"};

    for (int i = 0; i < 19; i++) begin
      if (tbl[i].is_rd) begin
        rd_chk(tbl[i].name, tbl[i].radr, tbl[i].exp);
      end else begin
        @(negedge clk);
        bus.sel = tbl[i].sel; bus.wr = 1'b1; bus.radr = tbl[i].radr; bus.wdata = tbl[i].wdata;
        @(negedge clk);
        bus_idle();
      end
    end

    // 1: edge source, pulse latency
    do_reset();
    wr_reg(REG_EN, 32'h04);
    @(negedge clk);
    src[2] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk($sformatf("t1_irq_c%0d", i), 32'(irq), 32'(i == 4));
      if (i == 2) src[2] = 1'b0;
    end
    rd_chk("t1_pend",  REG_PEND,  32'h04);
    rd_chk("t1_cause", REG_CAUSE, 32'h8000_0002);

    // 2: held in WAIT, EOI, gap, re-pulse
    wr_reg(REG_EN, 32'h24);
    @(negedge clk);
    src[5] = 1'b1;
    count_irq(2, c1);
    src[5] = 1'b0;
    count_irq(6, c2);
    chk("t2_wait_noirq", 32'(c1 + c2), 32'd0);
    rd_chk("t2_pend", REG_PEND, 32'h24);
    wr_reg(REG_PEND, 32'h04);
    wr_reg(REG_CAUSE, 32'h0);
    chk("t2_gap_low", 32'(irq), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("t2_repulse_c%0d", i), 32'(irq), 32'(i == 2));
    end
    rd_chk("t2_cause", REG_CAUSE, 32'h8000_0005);
    wr_reg(REG_PEND, 32'h20);
    wr_reg(REG_CAUSE, 32'h0);
    count_irq(4, c);
    chk("t2_quiet", 32'(c), 32'd0);

    // 3: level source, set beats W1C
    wr_reg(REG_TYPE, 32'h8000_00FD);
    @(negedge clk);
    src[1] = 1'b1;
    count_irq(4, c);
    wr_then_rd(REG_PEND, 32'h02, REG_PEND, 32'h02, "t3_set_wins");
    src[1] = 1'b0;
    count_irq(4, c);
    wr_reg(REG_PEND, 32'h02);
    rd_chk("t3_cleared", REG_PEND, 32'h00);
    wr_reg(REG_TYPE, 32'h8000_00FF);

    // 4: disabled source
    wr_reg(REG_EN, 32'h00);
    @(negedge clk);
    src[0] = 1'b1;
    count_irq(2, c1);
    src[0] = 1'b0;
    count_irq(6, c2);
    chk("t4_masked", 32'(c1 + c2), 32'd0);
    rd_chk("t4_pend", REG_PEND, 32'h01);
    wr_reg(REG_EN, 32'h01);
    count_irq(6, c);
    chk("t4_one_pulse", 32'(c), 32'd1);
    wr_reg(REG_PEND, 32'h01);
    wr_reg(REG_CAUSE, 32'h0);
    count_irq(3, c);

    // 5: software trigger
    wr_reg(REG_EN, 32'h80);
    wr_reg(REG_TYPE, 32'h0000_0080);
    count_irq(5, c);
    chk("t5_one_pulse", 32'(c), 32'd1);
    rd_chk("t5_pend",  REG_PEND,  32'h80);
    rd_chk("t5_cause", REG_CAUSE, 32'h8000_0007);

    // 6: reset while in WAIT
    wr_reg(REG_PEND, 32'h80);
    wr_reg(REG_TYPE, 32'h0000_0003);
    rd_chk("t6_pend_pre", REG_PEND, 32'h03);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_irq", 32'(irq), 32'd0);
    rd_chk("t6_pend",  REG_PEND,  32'h0);
    rd_chk("t6_en",    REG_EN,    32'h0);
    rd_chk("t6_cause", REG_CAUSE, 32'h0);
    rd_chk("t6_type",  REG_TYPE,  32'hFF);
    count_irq(8, c);
    chk("t6_no_spurious", 32'(c), 32'd0);

    // Randomised run against the reference model
    m_pend = '0; m_en = '0; m_type = 8'hFF; h1 = '0; h2 = '0; h3 = '0;
    m_irq = 0; m_busy = 0; m_cool = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rst = (cyc == 0) || ($urandom_range(0, 299) == 0);
      src = src ^ 8'($urandom & $urandom & $urandom);
      r = $urandom_range(0, 9);
      bus.sel = ($urandom_range(0, 9) != 0);
      bus.rd = (r >= 6);
      bus.wr = (r < 3);
      bus.radr = 2'($urandom);
      bus.wdata = $urandom;
      #1;
      if (cyc > 0) begin
        chk("rand_irq", 32'(irq), 32'(m_irq));
        if (!rst && bus.sel && bus.rd) chk("rand_rdata", bus.rdata, m_read(bus.radr));
      end

      // Advance the model across the coming clock edge
      if (rst) begin
        m_pend = '0; m_en = '0; m_type = 8'hFF; h1 = '0; h2 = '0; h3 = '0;
        m_irq = 0; m_busy = 0; m_cool = 0;
      end else begin
        isw = bus.sel && bus.wr;
        act = m_pend & m_en;
        set = (m_type & h2 & ~h3) | (~m_type & h2);
        w1c = (isw && bus.radr == 2'd0) ? bus.wdata[7:0] : 8'd0;
        sw  = (isw && bus.radr == 2'd3 && !bus.wdata[31]) ? bus.wdata[7:0] : 8'd0;
        npend = (m_pend & ~w1c) | set | sw;
        if (m_irq) begin
          m_irq = 0;
        end else if (m_busy) begin
          if (isw && bus.radr == 2'd2) begin
            m_busy = 0;
            m_cool = 1;
          end
        end else if (m_cool) begin
          m_cool = 0;
        end else if (act != 8'd0) begin
          m_irq = 1;
          m_busy = 1;
        end
        m_pend = npend;
        if (isw && bus.radr == 2'd1) m_en = bus.wdata[7:0];
        if (isw && bus.radr == 2'd3 && bus.wdata[31]) m_type = bus.wdata[7:0];
        h3 = h2; h2 = h1; h1 = src;
      end
    end
    @(negedge clk);
    bus_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
